// File: rtl/accel_spi_seq.sv
// accel_spi_seq: SPI sequencer for the Labyrinth tilt accelerometer.
// After a power-up wait it writes POWER_CTL = measure (0x0A 0x2D 0x02), then
// polls X/Y with a 4-byte read frame (0x0B 0x08 0x00 0x00) every POLL_PERIOD
// cycles. SPI mode 0, SPIclk half-period = CLK_DIV vgaclk cycles.
// Optional macro: ACCEL_AVG_EN -- when defined, each update averages the new
// sample with the previous output instead of loading it directly.
// Ports:
//   vgaclk      system clock
//   reset       synchronous active-high reset
//   MISO        serial data from accelerometer (sampled on SPIclk rise)
//   MOSI        serial data to accelerometer (changes on SPIclk fall)
//   SS          chip select, active low
//   SPIclk      SPI clock, idle low
//   x_tilt      signed X tilt, updated only in the UPD cycle
//   y_tilt      signed Y tilt, updated only in the UPD cycle
//   data_valid  one-cycle pulse coincident with a tilt update
//   init_done   set when the configuration frame finishes
//   busy        high during CFG, RD and the inter-frame gap
module accel_spi_seq #(
  parameter int unsigned CLK_DIV      = 16,
  parameter int unsigned PWRUP_CYCLES = 125000,
  parameter int unsigned POLL_PERIOD  = 416667
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SS,
  output logic       SPIclk,
  output logic [7:0] x_tilt,
  output logic [7:0] y_tilt,
  output logic       data_valid,
  output logic       init_done,
  output logic       busy
);

  localparam int unsigned WAIT_MAX = (PWRUP_CYCLES > 2 * CLK_DIV) ? PWRUP_CYCLES : 2 * CLK_DIV;
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned PW = $clog2(POLL_PERIOD + 1);

  localparam logic [WW-1:0] PWRUP_END = WW'(PWRUP_CYCLES);
  localparam logic [WW-1:0] GAP_END   = WW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END   = DW'(CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_END  = PW'(POLL_PERIOD - 1);

  localparam logic [7:0] CFG_B0 = 8'h0A;
  localparam logic [7:0] CFG_B1 = 8'h2D;
  localparam logic [7:0] CFG_B2 = 8'h02;
  localparam logic [7:0] RD_B0  = 8'h0B;
  localparam logic [7:0] RD_B1  = 8'h08;

  typedef enum logic [2:0] {
    PWRUP,
    CFG,
    GAP,
    IDLE,
    RD,
    UPD
  } state_e;

  state_e          state_q;
  logic [WW-1:0]   wait_q;
  logic [DW-1:0]   div_q;
  logic [4:0]      bit_q;
  logic [PW-1:0]   poll_q;
  logic [7:0]      rx_q;
  logic [7:0]      shx_q;
  logic [7:0]      shy_q;
  logic            gap_rd_q;

  logic [4:0]      bit_d;
  logic [7:0]      tx_byte_d;
  logic            mosi_d;
  logic [7:0]      rx_d;
  logic [4:0]      last_bit_d;
  logic [7:0]      x_upd_d;
  logic [7:0]      y_upd_d;
`ifdef ACCEL_AVG_EN
  logic [8:0]      sum_x_d;
  logic [8:0]      sum_y_d;
`endif

  always_comb begin
    bit_d     = bit_q + 5'd1;
    tx_byte_d = '0;
    if (state_q == RD) begin
      case (bit_d[4:3])
        2'd0:    tx_byte_d = RD_B0;
        2'd1:    tx_byte_d = RD_B1;
        default: tx_byte_d = '0;
      endcase
    end else begin
      case (bit_d[4:3])
        2'd0:    tx_byte_d = CFG_B0;
        2'd1:    tx_byte_d = CFG_B1;
        2'd2:    tx_byte_d = CFG_B2;
        default: tx_byte_d = '0;
      endcase
    end
    mosi_d     = tx_byte_d[3'd7 - bit_d[2:0]];
    rx_d       = {rx_q[6:0], MISO};
    last_bit_d = (state_q == RD) ? 5'd31 : 5'd23;
`ifdef ACCEL_AVG_EN
    // 9-bit signed sum; dropping bit 0 is an arithmetic shift right by one.
    sum_x_d = {x_tilt[7], x_tilt} + {shx_q[7], shx_q};
    sum_y_d = {y_tilt[7], y_tilt} + {shy_q[7], shy_q};
    x_upd_d = sum_x_d[8:1];
    y_upd_d = sum_y_d[8:1];
`else
    x_upd_d = shx_q;
    y_upd_d = shy_q;
`endif
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state_q    <= PWRUP;
      wait_q     <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      poll_q     <= '0;
      rx_q       <= '0;
      shx_q      <= '0;
      shy_q      <= '0;
      gap_rd_q   <= 1'b0;
      MOSI       <= 1'b0;
      SS         <= 1'b1;
      SPIclk     <= 1'b0;
      x_tilt     <= '0;
      y_tilt     <= '0;
      data_valid <= 1'b0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      // Saturating poll timer: a late IDLE entry launches immediately.
      if (poll_q != POLL_END) poll_q <= poll_q + 1'b1;

      unique case (state_q)
        PWRUP: begin
          if (wait_q == PWRUP_END) begin
            state_q <= CFG;
            SS      <= 1'b0;
            MOSI    <= CFG_B0[7];
            busy    <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        CFG, RD: begin
          if (div_q == DIV_END) begin
            div_q  <= '0;
            SPIclk <= ~SPIclk;
            if (!SPIclk) begin
              rx_q <= rx_d;
              if (state_q == RD && bit_q == 5'd23) shx_q <= rx_d;
              if (state_q == RD && bit_q == 5'd31) shy_q <= rx_d;
            end else if (bit_q == last_bit_d) begin
              // Final falling edge and SS release share this vgaclk edge.
              SS       <= 1'b1;
              MOSI     <= 1'b0;
              state_q  <= GAP;
              wait_q   <= '0;
              gap_rd_q <= (state_q == RD);
              if (state_q == CFG) init_done <= 1'b1;
            end else begin
              bit_q <= bit_d;
              MOSI  <= mosi_d;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end

        GAP: begin
          if (wait_q == GAP_END) begin
            busy   <= 1'b0;
            wait_q <= '0;
            if (gap_rd_q) begin
              state_q    <= UPD;
              data_valid <= 1'b1;
              x_tilt     <= x_upd_d;
              y_tilt     <= y_upd_d;
            end else begin
              // First read follows the configuration write without waiting.
              state_q <= IDLE;
              poll_q  <= POLL_END;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end

        IDLE: begin
          if (poll_q == POLL_END) begin
            state_q <= RD;
            SS      <= 1'b0;
            MOSI    <= RD_B0[7];
            busy    <= 1'b1;
            div_q   <= '0;
            bit_q   <= '0;
            poll_q  <= '0;
          end
        end

        UPD: state_q <= IDLE;

        default: state_q <= PWRUP;
      endcase
    end
  end

endmodule

// File: doc/accel_spi_seq.md
Name: accel_spi_seq

Overview:
Sequences all SPI traffic to the tilt accelerometer for the Labyrinth game. After power-up it writes the accelerometer's measurement-mode configuration. It then polls X/Y tilt bytes at a fixed rate and presents them as registered signed values to the ball-physics logic. It contains its own SPI mode-0 shift engine, clocked from vgaclk.

Parameters:
CLK_DIV, 16, vgaclk cycles per SPIclk half-period; must be >= 2
PWRUP_CYCLES, 125000, vgaclk cycles to wait after reset before the first transaction; must be >= 1
POLL_PERIOD, 416667, vgaclk cycles between read launches (~60 Hz at 25 MHz)

Ports:
vgaclk  input  1  system clock
reset  input  1  synchronous, active-high reset
MISO  input  1  serial data from accelerometer
MOSI  output  1  serial data to accelerometer
SS  output  1  chip select, active low
SPIclk  output  1  SPI clock, idle low
x_tilt  output  8  signed X acceleration, two's complement
y_tilt  output  8  signed Y acceleration, two's complement
data_valid  output  1  one-cycle pulse when x_tilt/y_tilt update
init_done  output  1  high once the configuration write has completed
busy  output  1  high while SS is low or the inter-frame gap is running

Behaviour:
- Reset values: MOSI=0, SS=1, SPIclk=0, x_tilt=0, y_tilt=0, data_valid=0, init_done=0, busy=0. State=PWRUP; all counters cleared.
- Reset has priority over everything. Reset mid-transaction forces SS=1 and SPIclk=0 on the next edge and restarts from PWRUP.
- States: PWRUP -> CFG -> GAP -> IDLE -> RD -> GAP -> UPD -> IDLE ...
- PWRUP: counts PWRUP_CYCLES cycles, then enters CFG.
- CFG: 3-byte frame 0x0A, 0x2D, 0x02 (write POWER_CTL = measure). At the end of the frame init_done is set and stays 1 until reset.
- RD: 4-byte frame 0x0B, 0x08, dummy 0x00, dummy 0x00.
  - Byte 2 is captured from MISO into x_tilt shadow; byte 3 into y_tilt shadow.
  - MOSI is 0 during the dummy bytes.
- Frame timing, SPI mode 0:
  - SS falls on the state-entry edge; MOSI carries the MSB of byte 0 on that same edge.
  - SPIclk toggles every CLK_DIV cycles: first rise CLK_DIV cycles after SS falls.
  - MISO is sampled on each rising edge.
  - MOSI advances to the next bit on each falling edge. Bytes are MSB first and back-to-back, with no gap between bytes.
  - After the last rising edge, the final falling edge and SS rise occur on the same vgaclk edge.
  - SS-low duration = 16*CLK_DIV*N cycles for an N-byte frame (CFG: 48*CLK_DIV; RD: 64*CLK_DIV).
- GAP: SS held high, SPIclk low, MOSI=0 for 2*CLK_DIV cycles.
  - After the CFG frame, GAP goes to IDLE and the first read launches immediately.
  - After an RD frame, GAP goes to UPD.
- UPD: single cycle. x_tilt/y_tilt load from the shadows and data_valid=1 in that cycle only. Next state is IDLE.
- Poll timer:
  - Reloads to 0 on each RD launch and counts every cycle.
  - IDLE launches RD when the timer reaches POLL_PERIOD-1.
  - If POLL_PERIOD is shorter than RD+GAP+UPD length, RD launches on the first IDLE cycle (no queueing, no skipped-read accounting).
- busy = 1 in CFG, RD and GAP; 0 otherwise.
- MISO is treated as synchronous to vgaclk. The SPIclk period makes a synchronizer unnecessary.
- Outputs x_tilt/y_tilt hold their last value between updates and never change outside UPD.

Optional Feature:
ACCEL_AVG_EN
- Defined: in UPD, x_tilt <= (x_tilt + shadow_x) >>> 1, computed as a 9-bit signed sum and truncated to 8 bits (arithmetic shift, rounds toward -inf); y likewise. data_valid timing is unchanged.
- Undefined: direct load as described above.

Test Plan:
- Params CLK_DIV=2, PWRUP_CYCLES=10: release reset at cycle 0 -> SS stays 1 through cycle 9, falls at cycle 10, low exactly 96 cycles. Decoded MOSI = 0x0A,0x2D,0x02; init_done rises when SS rises.
- Same params, model returns X=0x12, Y=0xF0 -> RD frame decodes MOSI 0x0B,0x08,0x00,0x00; SS low 128 cycles. data_valid pulses once, 4 cycles after SS rises, with x_tilt=0x12, y_tilt=0xF0.
- POLL_PERIOD=400 -> consecutive RD SS falling edges exactly 400 cycles apart; POLL_PERIOD=50 -> next SS fall on first IDLE cycle after UPD.
- Assert reset during byte 1 of an RD frame -> SS=1, SPIclk=0 next cycle; init_done=0; x_tilt/y_tilt=0; no data_valid; CFG frame repeats after 10 cycles.
- Check SPI mode-0 timing throughout -> SPIclk is never high while SS=1. MOSI only changes on SPIclk falling edges or SS fall, with exactly 8 rising edges per byte.
- ACCEL_AVG_EN defined, x_tilt=0x10, new sample 0x80 -> x_tilt=0xC8 (16 + -128 = -112, >>>1 = -56).
